// File: rtl/parallel_alu.sv
// rtl/parallel_alu.sv - 181-style 4-bit ALU with one registered output stage
//
// Purpose: combinational '181 function core (16 logic + 16 arithmetic
// functions selected by S/M, carry-in Pin) followed by a register stage.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears R/P (and Z)
//   A, B - WIDTH-bit operands
//   S    - 4-bit function select
//   M    - 1 = logic mode, 0 = arithmetic mode
//   Pin  - carry-in (1 = plus one), ignored in logic mode
//   R    - registered result
//   P    - registered per-bit carry-out, P[WIDTH-1] is the final carry
//   Z    - registered zero flag, present only with PARALLEL_ALU_ZERO_FLAG_EN
// Optional feature macro: PARALLEL_ALU_ZERO_FLAG_EN

module parallel_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Pin,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] P
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
    ,
    output logic             Z
`endif
);

    logic [WIDTH-1:0] x_term;
    logic [WIDTH-1:0] y_term;
    logic [WIDTH-1:0] r_d, r_q;
    logic [WIDTH-1:0] p_d, p_q;
    logic             carry;

    // Per-bit generate/propagate-style terms shared by both modes.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            x_term[i] = A[i] | (B[i] & S[0]) | (~B[i] & S[1]);
            y_term[i] = (A[i] & ~B[i] & S[2]) | (A[i] & B[i] & S[3]);
        end
    end

    always_comb begin
        r_d   = '0;
        p_d   = '0;
        carry = Pin;
        if (M) begin
            // Logic mode: no carry chain, carry outputs forced low.
            r_d = ~(x_term ^ y_term);
        end else begin
            // Arithmetic mode: ripple X + Y + Pin, exposing every carry.
            for (int i = 0; i < WIDTH; i++) begin
                r_d[i] = x_term[i] ^ y_term[i] ^ carry;
                p_d[i] = (x_term[i] & y_term[i]) | (x_term[i] & carry) | (y_term[i] & carry);
                carry  = p_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            p_q <= '0;
        end else begin
            r_q <= r_d;
            p_q <= p_d;
        end
    end

    assign R = r_q;
    assign P = p_q;

`ifdef PARALLEL_ALU_ZERO_FLAG_EN
    logic z_d, z_q;

    always_comb begin
        z_d = (r_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    assign Z = z_q;
`endif

endmodule

// File: tb/tb_parallel_alu.sv
// tb/tb_parallel_alu.sv - directed self-checking bench for parallel_alu

module tb_parallel_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B, S;
    logic       M, Pin;
    logic [3:0] R, P;
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
    logic       Z;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    parallel_alu #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .S   (S),
        .M   (M),
        .Pin (Pin),
        .R   (R),
        .P   (P)
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
        ,
        .Z   (Z)
`endif
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic step(input logic r, input logic m, input logic [3:0] s,
                        input logic [3:0] a, input logic [3:0] b, input logic pin);
        @(negedge clk);
        rst = r; M = m; S = s; A = a; B = b; Pin = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rp(input string tag, input logic [3:0] r_exp, input logic [3:0] p_exp);
        check_eq({tag, ".R"}, {4'b0, R}, {4'b0, r_exp});
        check_eq({tag, ".P"}, {4'b0, P}, {4'b0, p_exp});
    endtask

    initial begin
        rst = 1'b1; M = 1'b0; S = 4'b1001; A = 4'd9; B = 4'd1; Pin = 1'b0;

        // Reset edge with a live add on the inputs
        step(1'b1, 1'b0, 4'b1001, 4'd9, 4'd1, 1'b0);
        expect_rp("reset", 4'd0, 4'b0000);
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
        check_eq("reset.Z", {7'b0, Z}, 8'd0);
`endif
        // First result one edge after rst drops: 9+1
        step(1'b0, 1'b0, 4'b1001, 4'd9, 4'd1, 1'b0);
        expect_rp("first_add", 4'd10, 4'b0001);

        // A|B, then A|B plus 1
        step(1'b0, 1'b0, 4'b0001, 4'd3, 4'd11, 1'b0);
        expect_rp("or_pin0", 4'd11, 4'b0000);
        step(1'b0, 1'b0, 4'b0001, 4'd3, 4'd11, 1'b1);
        expect_rp("or_pin1", 4'd12, 4'b0011);

        // A + (A&~B)
        step(1'b0, 1'b0, 4'b0100, 4'd7, 4'd8, 1'b0);
        expect_rp("a_plus_anb", 4'd14, 4'b0111);

        // A - B with Pin=1: 5-3
        step(1'b0, 1'b0, 4'b0110, 4'd5, 4'd3, 1'b1);
        expect_rp("sub", 4'd2, 4'b1101);

        // A - 1 from zero wraps to 15
        step(1'b0, 1'b0, 4'b1111, 4'd0, 4'd6, 1'b0);
        expect_rp("dec_zero", 4'd15, 4'b0000);

        // All-ones plus 1: wraps to 0, carry through every bit
        step(1'b0, 1'b0, 4'b0011, 4'd6, 4'd9, 1'b1);
        expect_rp("ones_plus1", 4'd0, 4'b1111);

        // Logic XOR, Pin ignored
        step(1'b0, 1'b1, 4'b0110, 4'd12, 4'd4, 1'b1);
        expect_rp("logic_xor", 4'd8, 4'b0000);

        // Logic XNOR
        step(1'b0, 1'b1, 4'b1001, 4'd5, 4'd13, 1'b0);
        expect_rp("logic_xnor", 4'd7, 4'b0000);

        // Logic constant zero
        step(1'b0, 1'b1, 4'b0011, 4'd9, 4'd6, 1'b1);
        expect_rp("logic_zero", 4'd0, 4'b0000);
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
        check_eq("logic_zero.Z", {7'b0, Z}, 8'd1);
`endif

        // Logic constant ones
        step(1'b0, 1'b1, 4'b1100, 4'd3, 4'd10, 1'b0);
        expect_rp("logic_ones", 4'd15, 4'b0000);
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
        check_eq("logic_ones.Z", {7'b0, Z}, 8'd0);
`endif

        // 15+1 overflow: R=0, all carries set
        step(1'b0, 1'b0, 4'b1001, 4'd15, 4'd1, 1'b0);
        expect_rp("overflow", 4'd0, 4'b1111);
`ifdef PARALLEL_ALU_ZERO_FLAG_EN
        check_eq("overflow.Z", {7'b0, Z}, 8'd1);
`endif

        // Back-to-back stream with a reset in the middle
        step(1'b0, 1'b0, 4'b1001, 4'd2, 4'd3, 1'b0);
        expect_rp("stream0", 4'd5, 4'b0010);
        // Inputs change before the next edge; register must hold
        @(negedge clk);
        A = 4'd4; B = 4'd4;
        #1;
        expect_rp("stream0_hold", 4'd5, 4'b0010);
        step(1'b1, 1'b0, 4'b1001, 4'd15, 4'd15, 1'b1);
        expect_rp("stream_rst", 4'd0, 4'b0000);
        step(1'b0, 1'b0, 4'b1001, 4'd4, 4'd4, 1'b0);
        expect_rp("stream1", 4'd8, 4'b0100);
        step(1'b0, 1'b1, 4'b0000, 4'd10, 4'd0, 1'b0);
        expect_rp("stream2_notA", 4'd5, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parallel_alu.md
Name: parallel_alu

Overview:
- 4-bit parallel ALU implementing the classic '181-style function set: 16 logic and 16 arithmetic functions, selected by S and M, with carry-in Pin.
- Combinational function core followed by one output register stage, so results are synchronous to the datapath clock.
- Used as the execution unit of the central unit's datapath. Also exposes the per-bit ripple carries for observation and chaining.

Parameters:
- WIDTH, 4, operand/result width; all rules below scale bitwise with WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- S  input  4  function select
- M  input  1  mode: 1 = logic, 0 = arithmetic
- Pin  input  1  carry-in, active-high (1 = "plus 1"); ignored when M=1
- R  output  WIDTH  registered result
- P  output  WIDTH  registered per-bit carry-out; P[i] is the carry out of bit i, so P[WIDTH-1] is the final carry

Behaviour:
- Reset: on a rising clk edge with rst=1, R and P are cleared to 0. Reset has priority over any operation in flight.
- Latency: inputs sampled at edge n appear on R/P after edge n; one result per cycle; no handshake.
- Per-bit intermediate terms:
  - X[i] = A[i] | (B[i]&S[0]) | (~B[i]&S[1])
  - Y[i] = (A[i]&~B[i]&S[2]) | (A[i]&B[i]&S[3])
- Arithmetic (M=0):
  - Ripple add R = X + Y + Pin, modulo 2^WIDTH.
  - c[-1] = Pin; P[i] = majority(X[i], Y[i], c[i-1]).
- Resulting arithmetic table (Pin=0; add 1 when Pin=1):
  - 0000 A; 0001 A|B; 0010 A|~B; 0011 all-ones
  - 0100 A+(A&~B); 0101 (A|B)+(A&~B); 0110 A-B-1; 0111 (A&~B)-1
  - 1000 A+(A&B); 1001 A+B; 1010 (A|~B)+(A&B); 1011 (A&B)-1
  - 1100 A+A; 1101 (A|B)+A; 1110 (A|~B)+A; 1111 A-1
- Logic (M=1):
  - R = ~(X ^ Y) bitwise; P = 0; Pin ignored.
  - Table: 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0; 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B; 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B; 1100 all-ones; 1101 A|~B; 1110 A|B; 1111 A.
- Wrap-around: overflow is discarded from R and is visible only as P[WIDTH-1].
- Unknown or X inputs: no special handling.

Optional Feature:
- Macro PARALLEL_ALU_ZERO_FLAG_EN.
- Defined: adds output port Z (1 bit, registered together with R). Z = 1 when the next R equals 0, in both modes. Reset drives Z to 0.
- Undefined: port Z and its logic do not exist; all other behaviour is unchanged.

Test Plan:
- rst=1 for one edge with A=9, B=1, M=0, S=1001 -> R=0, P=0 after that edge; first result appears one edge after rst drops.
- M=0, S=0001, A=3, B=11, Pin=0 -> next edge R=11, P=0000. Same inputs with Pin=1 -> R=12, P=0011.
- M=0, S=0100, A=7, B=8, Pin=0 -> R=14, P=0111.
- M=1, S=0110, A=12, B=4, Pin=1 -> R=8, P=0 (Pin ignored). Then S=1001, A=5, B=13 -> R=7.
- M=0, S=1001, A=15, B=1, Pin=0 -> R=0, P=1111; Z=1 when PARALLEL_ALU_ZERO_FLAG_EN is defined.
- Back-to-back vectors on consecutive cycles with rst asserted mid-stream -> each result lags its inputs by exactly one edge; the reset edge forces R=0, P=0.
